// File: rtl/iir_pkg.sv
// Shared Q2.16 widths, FSM state encoding, coefficient address map and output scaling
// for the serial DF2T IIR filter.
package iir_pkg;

    localparam int unsigned DATA_W      = 18;
    localparam int unsigned FRAC_W      = 16;
    localparam int unsigned PROD_W      = 2 * DATA_W;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned SCALE_W     = 3;
    localparam int unsigned COEF_ADDR_W = 4;
    localparam int unsigned SHIFT_EXT   = (2 ** SCALE_W) - 1;

    localparam logic [DATA_W-1:0] SAT_POS = 18'h1FFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 18'h20000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_Y = 2'd1,
        CALC_S = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index width for an array of n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Coefficient store: b1..b(ORDER+1) at 0..ORDER, a2..a(ORDER+1) follow.
    function automatic int unsigned coef_b_addr(input int unsigned n);
        return n - 1;
    endfunction

    function automatic int unsigned coef_a_addr(input int unsigned order, input int unsigned n);
        return order + n - 1;
    endfunction

    // Left shift inside 18 bits; optional clamp when the value does not fit.
    function automatic logic [DATA_W-1:0] scale_q(input logic [DATA_W-1:0] y,
                                                  input logic [SCALE_W-1:0] sh,
                                                  input logic sat);
        logic [DATA_W+SHIFT_EXT-1:0] wide;
        logic                        ovf;
        wide = {{SHIFT_EXT{y[DATA_W-1]}}, y} << sh;
        ovf  = (wide[DATA_W+SHIFT_EXT-1:DATA_W-1] != {(SHIFT_EXT+1){y[DATA_W-1]}});
        if (sat && ovf) begin
            return y[DATA_W-1] ? SAT_NEG : SAT_POS;
        end
        return wide[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/iir_df2t_serial_if.sv
// Sample, control and coefficient-load bundle of the serial IIR filter.
interface iir_df2t_serial_if #(
    parameter int unsigned NCH = 2
) ();
    import iir_pkg::*;

    logic                      sample_valid;
    logic [NCH*SAMPLE_W-1:0]   audio_in;
    logic [SCALE_W-1:0]        scale;
    logic                      sat_en;
    logic                      coef_we;
    logic [COEF_ADDR_W-1:0]    coef_addr;
    logic [DATA_W-1:0]         coef_data;
    logic [NCH*SAMPLE_W-1:0]   audio_out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output sample_valid, audio_in, scale, sat_en, coef_we, coef_addr, coef_data,
        input  audio_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_valid, audio_in, scale, sat_en, coef_we, coef_addr, coef_data,
        output audio_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/iir_df2t_serial_signed_mult.sv
// Q2.16 x Q2.16 multiplier, product reduced back to Q2.16 with the true sign kept.
module signed_mult
    import iir_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] prod_c
);
    logic signed [PROD_W-1:0]   full;
    logic [PROD_W-DATA_W-1:0]   unused_bits;

    assign full        = $signed(a) * $signed(b);
    assign prod_c      = {full[PROD_W-1], full[FRAC_W+DATA_W-2:FRAC_W]};
    assign unused_bits = {full[PROD_W-2:FRAC_W+DATA_W-1], full[FRAC_W-1:0]};
endmodule

// File: rtl/iir_df2t_serial.sv
// Multichannel Direct Form II Transposed IIR filter, evaluated one term per cycle
// with one shared b-multiplier and one shared a-multiplier.
module iir_df2t_serial
    import iir_pkg::*;
#(
    parameter int unsigned ORDER = 4,
    parameter int unsigned NCH   = 2
) (
    input  logic             state_clk,
    input  logic             reset,
    iir_df2t_serial_if.slave bus
);
    localparam int unsigned NS     = NCH * ORDER;
    localparam int unsigned NC     = 2 * ORDER + 1;
    localparam int unsigned SIDX_W = idx_w(NS);
    localparam int unsigned CIDX_W = idx_w(NC);
    localparam int unsigned CH_W   = idx_w(NCH);
    localparam int unsigned K_W    = idx_w(ORDER + 1);

    state_t                 state, state_next;
    logic [CH_W-1:0]        ch;
    logic [K_W-1:0]         k;
    logic [SAMPLE_W-1:0]    x_lat  [NCH];
    logic [SAMPLE_W-1:0]    y_hold [NCH];
    logic [SCALE_W-1:0]     scale_lat;
    logic                   sat_lat;
    logic [DATA_W-1:0]      y_reg;
    logic [DATA_W-1:0]      s_reg  [NS];
    logic [DATA_W-1:0]      coef   [NC];
    logic [NCH*SAMPLE_W-1:0] audio_out;
    logic                   out_valid;
    logic                   busy;
    logic                   overrun;

    logic                   last_k_c, last_ch_c, coef_addr_ok_c;
    logic [SIDX_W-1:0]      s_rd_idx_c, s_wr_idx_c;
    logic [CIDX_W-1:0]      cb_idx_c, ca_idx_c;
    logic [DATA_W-1:0]      x_cur_c, prod_b_c, prod_a_c, y_new_c, s_next_c, s_rd_c;

    // State register.
    always_ff @(posedge state_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sample_valid) state_next = CALC_Y;
            CALC_Y:  state_next = CALC_S;
            CALC_S:  if (last_k_c) state_next = last_ch_c ? DONE : CALC_Y;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // k = 0 selects b1/s1 during CALC_Y; k = 1..ORDER walks the state updates.
    always_comb begin
        last_k_c       = (k == K_W'(ORDER));
        last_ch_c      = (ch == CH_W'(NCH - 1));
        coef_addr_ok_c = (int'(bus.coef_addr) <= int'(2 * ORDER));
        s_rd_idx_c     = SIDX_W'(int'(ch) * int'(ORDER) + int'(k));
        s_wr_idx_c     = SIDX_W'(int'(ch) * int'(ORDER) + int'(k) - 1);
        cb_idx_c       = CIDX_W'(coef_b_addr(int'(k) + 1));
        ca_idx_c       = CIDX_W'(coef_a_addr(ORDER, int'(k) + 1));
        x_cur_c        = {x_lat[ch], 2'b00};
        s_rd_c         = last_k_c ? '0 : s_reg[s_rd_idx_c];
        y_new_c        = scale_q(s_reg[s_rd_idx_c] + prod_b_c, scale_lat, sat_lat);
        s_next_c       = prod_b_c + s_rd_c + prod_a_c;
    end

    signed_mult u_mult_b (.a(coef[cb_idx_c]), .b(x_cur_c), .prod_c(prod_b_c));
    signed_mult u_mult_a (.a(coef[ca_idx_c]), .b(y_reg),   .prod_c(prod_a_c));

    // Coefficient store, writable only while idle.
    always_ff @(posedge state_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NC); i++) coef[i] <= '0;
        end else if (bus.coef_we && (state == IDLE) && coef_addr_ok_c) begin
            coef[CIDX_W'(bus.coef_addr)] <= bus.coef_data;
        end
    end

    // Per-channel delay-line state.
    always_ff @(posedge state_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NS); i++) s_reg[i] <= '0;
        end else if (state == CALC_S) begin
            s_reg[s_wr_idx_c] <= s_next_c;
        end
    end

    // Sequencing counters, input capture and output registers.
    always_ff @(posedge state_clk or posedge reset) begin
        if (reset) begin
            ch        <= '0;
            k         <= '0;
            scale_lat <= '0;
            sat_lat   <= 1'b0;
            y_reg     <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < int'(NCH); c++) begin
                x_lat[c]  <= '0;
                y_hold[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            busy      <= (state_next != IDLE);
            if (bus.sample_valid && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    ch <= '0;
                    k  <= '0;
                    if (bus.sample_valid) begin
                        for (int c = 0; c < int'(NCH); c++)
                            x_lat[c] <= bus.audio_in[c*SAMPLE_W +: SAMPLE_W];
                        scale_lat <= bus.scale;
                        sat_lat   <= bus.sat_en;
                    end
                end
                CALC_Y: begin
                    y_reg      <= y_new_c;
                    y_hold[ch] <= y_new_c[DATA_W-1:2];
                    k          <= K_W'(1);
                end
                CALC_S: begin
                    if (last_k_c) begin
                        k  <= '0;
                        ch <= ch + CH_W'(1);
                        if (last_ch_c) begin
                            out_valid <= 1'b1;
                            for (int c = 0; c < int'(NCH); c++)
                                audio_out[c*SAMPLE_W +: SAMPLE_W] <= y_hold[c];
                        end
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.audio_out = audio_out;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_iir_df2t_serial.sv
// Bench for iir_df2t_serial: directed cases plus randomized sample sets checked
// against a plain-arithmetic filter model.
module tb_iir_df2t_serial;
    localparam int unsigned ORDER = 4;
    localparam int unsigned NCH   = 2;
    localparam int unsigned AW    = NCH * 16;
    localparam int          LAT   = NCH * (ORDER + 1) + 1;

    logic state_clk;
    logic reset;

    iir_df2t_serial_if #(.NCH(NCH)) bus ();

    iir_df2t_serial #(.ORDER(ORDER), .NCH(NCH)) dut (
        .state_clk (state_clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial state_clk = 1'b0;
    always #5 state_clk = ~state_clk;

    int n_cmp;
    int n_bad;

    int          mb [ORDER+2];
    int          ma [ORDER+2];
    int          ms [NCH][ORDER+2];
    logic [15:0] exp_out [NCH];
    bit          exp_ovr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wrap18(input longint v);
        longint m;
        m = v % 262144;
        if (m < 0) m += 262144;
        if (m >= 131072) m -= 262144;
        return int'(m);
    endfunction

    function automatic int qmul(input int c, input int x);
        longint p, hi;
        p  = longint'(c) * longint'(x);
        hi = (p >>> 16) & 64'h1FFFF;
        return (p < 0) ? int'(hi) - 131072 : int'(hi);
    endfunction

    function automatic int qscale(input int y, input int sh, input bit sat);
        longint v;
        v = longint'(y) * (longint'(1) << sh);
        if (sat && v > 131071)  return 131071;
        if (sat && v < -131072) return -131072;
        return wrap18(v);
    endfunction

    function automatic int to_s18(input logic [17:0] v);
        return v[17] ? int'(v) - 262144 : int'(v);
    endfunction

    task automatic model_clear();
        for (int n = 0; n < ORDER + 2; n++) begin
            mb[n] = 0;
            ma[n] = 0;
            for (int c = 0; c < NCH; c++) ms[c][n] = 0;
        end
        exp_ovr = 1'b0;
    endtask

    // One sample set through the filter equations, using the pre-update state.
    task automatic model_step(input logic [AW-1:0] xin, input int sh, input bit sat);
        for (int c = 0; c < NCH; c++) begin
            int          x, y;
            int          ns [ORDER+2];
            logic [15:0] xs;
            xs = xin[c*16 +: 16];
            x  = int'($signed(xs)) * 4;
            y  = qscale(wrap18(longint'(ms[c][1]) + qmul(mb[1], x)), sh, sat);
            for (int n = 1; n <= int'(ORDER); n++)
                ns[n] = wrap18(longint'(qmul(mb[n+1], x)) + ms[c][n+1] + qmul(ma[n+1], y));
            for (int n = 1; n <= int'(ORDER); n++) ms[c][n] = ns[n];
            exp_out[c] = 16'(y >>> 2);
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.coef_we      = 1'b0;
        @(posedge state_clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [17:0] data);
        int a;
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr;
        bus.coef_data = data;
        @(posedge state_clk); #1;
        bus.coef_we = 1'b0;
        a = int'(addr);
        if (a <= int'(ORDER))          mb[a+1] = to_s18(data);
        else if (a <= int'(2 * ORDER)) ma[a-int'(ORDER)+1] = to_s18(data);
    endtask

    // Drive one sample set, optionally a stray sample_valid and/or a coefficient
    // write at a given busy cycle, then check timing, outputs and hold.
    task automatic run_set(input logic [AW-1:0] xin, input logic [2:0] sh, input bit sat,
                           input int inject_cyc, input int coef_cyc);
        int            cyc;
        bit            busy_ok;
        logic [AW-1:0] held;
        bus.audio_in     = xin;
        bus.scale        = sh;
        bus.sat_en       = sat;
        bus.sample_valid = 1'b1;
        model_step(xin, int'(sh), sat);
        if (inject_cyc > 0) exp_ovr = 1'b1;
        @(posedge state_clk); #1;
        bus.sample_valid = 1'b0;
        bus.audio_in     = AW'({$urandom, $urandom, $urandom, $urandom});
        bus.scale        = 3'($urandom);
        bus.sat_en       = 1'($urandom);
        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && cyc < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            bus.sample_valid = (cyc == inject_cyc);
            if (cyc == coef_cyc) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = 4'($urandom_range(0, 2 * ORDER));
                bus.coef_data = 18'($urandom);
            end else begin
                bus.coef_we = 1'b0;
            end
            @(posedge state_clk); #1;
            cyc++;
        end
        bus.sample_valid = 1'b0;
        bus.coef_we      = 1'b0;
        check_eq("latency", 64'(cyc), 64'(LAT));
        check_eq("busy_run", 64'(busy_ok), 64'd1);
        check_eq("busy_done", 64'(bus.busy), 64'd1);
        for (int c = 0; c < NCH; c++)
            check_eq($sformatf("lane%0d", c), 64'(bus.audio_out[c*16 +: 16]), 64'(exp_out[c]));
        held = bus.audio_out;
        @(posedge state_clk); #1;
        check_eq("valid_pulse", 64'(bus.out_valid), 64'd0);
        check_eq("busy_idle", 64'(bus.busy), 64'd0);
        check_eq("out_hold", 64'(bus.audio_out), 64'(held));
        check_eq("overrun", 64'(bus.overrun), 64'(exp_ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  seen;
        int  v;
        n_cmp            = 0;
        n_bad            = 0;
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.audio_in     = '0;
        bus.scale        = '0;
        bus.sat_en       = 1'b0;
        bus.coef_we      = 1'b0;
        bus.coef_addr    = '0;
        bus.coef_data    = '0;
        @(posedge state_clk); #1;
        do_reset();
        check_eq("rst_out", 64'(bus.audio_out), 64'd0);
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_overrun", 64'(bus.overrun), 64'd0);

        // Gain of one half.
        write_coef(4'd0, 18'h08000);
        run_set({16'h4000, 16'h4000}, 3'd0, 1'b0, 0, 0);
        check_eq("gain", 64'(bus.audio_out), 64'h2000_2000);

        // Pure one-sample delay.
        do_reset();
        write_coef(4'd1, 18'h10000);
        run_set({16'h1234, 16'h1234}, 3'd0, 1'b0, 0, 0);
        check_eq("delay0", 64'(bus.audio_out), 64'h0000_0000);
        run_set({16'h0000, 16'h0000}, 3'd0, 1'b0, 0, 0);
        check_eq("delay1", 64'(bus.audio_out), 64'h1234_1234);

        // Single pole at one half.
        do_reset();
        write_coef(4'd0, 18'h10000);
        write_coef(4'(ORDER + 1), 18'h08000);
        run_set({16'h4000, 16'h4000}, 3'd0, 1'b0, 0, 0);
        check_eq("pole0", 64'(bus.audio_out), 64'h4000_4000);
        run_set('0, 3'd0, 1'b0, 0, 0);
        check_eq("pole1", 64'(bus.audio_out), 64'h2000_2000);
        run_set('0, 3'd0, 1'b0, 0, 0);
        check_eq("pole2", 64'(bus.audio_out), 64'h1000_1000);

        // Output shift: wrap versus clamp.
        do_reset();
        write_coef(4'd0, 18'h10000);
        run_set({16'h4000, 16'h4000}, 3'd2, 1'b0, 0, 0);
        check_eq("wrap", 64'(bus.audio_out), 64'h0000_0000);
        run_set({16'h4000, 16'h4000}, 3'd2, 1'b1, 0, 0);
        check_eq("sat", 64'(bus.audio_out), 64'h7FFF_7FFF);
        run_set({16'hC000, 16'h8000}, 3'd3, 1'b1, 0, 0);
        check_eq("sat_neg", 64'(bus.audio_out), 64'h8000_8000);

        // Channel isolation with a stray sample_valid while busy.
        do_reset();
        write_coef(4'd0, 18'h10000);
        write_coef(4'(ORDER + 1), 18'h08000);
        run_set({16'h0000, 16'h4000}, 3'd0, 1'b0, 5, 0);
        check_eq("indep0", 64'(bus.audio_out), 64'h0000_4000);
        run_set('0, 3'd0, 1'b0, 0, 0);
        check_eq("indep1", 64'(bus.audio_out), 64'h0000_2000);

        // Reset in the middle of a computation.
        bus.audio_in     = {16'h4000, 16'h4000};
        bus.sample_valid = 1'b1;
        @(posedge state_clk); #1;
        bus.sample_valid = 1'b0;
        repeat (3) begin @(posedge state_clk); #1; end
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_ovr", 64'(bus.overrun), 64'd0);
        @(posedge state_clk); #1;
        reset = 1'b0;
        model_clear();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen++;
            @(posedge state_clk); #1;
        end
        check_eq("midrst_novalid", 64'(seen), 64'd0);
        write_coef(4'd0, 18'h10000);
        write_coef(4'(ORDER + 1), 18'h08000);
        run_set('0, 3'd0, 1'b0, 0, 0);
        check_eq("midrst_zero", 64'(bus.audio_out), 64'h0000_0000);
        run_set({16'h4000, 16'h4000}, 3'd0, 1'b0, 0, 0);
        check_eq("midrst_imp", 64'(bus.audio_out), 64'h4000_4000);

        // Random coefficients and samples; writes while busy and out of range are dropped.
        do_reset();
        for (int a = 0; a <= int'(2 * ORDER); a++) begin
            v = int'($urandom_range(0, 'hC000)) - 'h6000;
            write_coef(4'(a), 18'(v));
        end
        for (int a = int'(2 * ORDER) + 1; a < 16; a++) write_coef(4'(a), 18'($urandom));
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 9) begin
                v = int'($urandom_range(0, 'hC000)) - 'h6000;
                write_coef(4'($urandom_range(0, 2 * ORDER)), 18'(v));
            end
            run_set(AW'({$urandom, $urandom, $urandom, $urandom}),
                    3'($urandom_range(0, 3)), 1'($urandom),
                    (i % 7 == 3) ? int'($urandom_range(1, 11)) : 0,
                    (i % 4 == 0) ? 3 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
